// File: rtl/seq_divider_if.sv
// Start/busy divide handshake between the CPU (master) and the iterative divider (slave).
`timescale 1ns/1ps
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sign;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;

    modport master (
        output start, sign, dividend, divisor,
        input  q, r, busy, done
    );

    modport slave (
        input  start, sign, dividend, divisor,
        output q, r, busy, done
    );
endinterface

// File: rtl/seq_divider.sv
// Fixed-latency restoring divider, signed or unsigned per operation, WIDTH steps per result.
`timescale 1ns/1ps
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  io_divBus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state, w_nextState;
    logic [CW-1:0]    r_count, w_count;
    logic [WIDTH-1:0] r_partRem, w_partRem;
    logic [WIDTH-1:0] r_quo, w_quo;
    logic [WIDTH-1:0] r_magDivisor, w_magDivisor;
    logic [WIDTH-1:0] r_origDividend, w_origDividend;
    logic [WIDTH-1:0] r_q, w_q;
    logic [WIDTH-1:0] r_r, w_r;
    logic             r_quoNeg, w_quoNeg;
    logic             r_remNeg, w_remNeg;
    logic             r_divZero, w_divZero;
    logic             r_done, w_done;

    logic             w_dividendNeg, w_divisorNeg;
    logic [WIDTH-1:0] w_magDividend, w_magDivisorIn;
    logic [WIDTH:0]   w_remShift, w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] w_stepRem, w_stepQuo;
    logic             w_lastStep;

    assign w_dividendNeg  = io_divBus.sign & io_divBus.dividend[WIDTH-1];
    assign w_divisorNeg   = io_divBus.sign & io_divBus.divisor[WIDTH-1];
    assign w_magDividend  = w_dividendNeg ? -io_divBus.dividend : io_divBus.dividend;
    assign w_magDivisorIn = w_divisorNeg  ? -io_divBus.divisor  : io_divBus.divisor;

    // The partial remainder stays below the divisor, so one extra bit is enough for the trial subtract.
    assign w_remShift = {r_partRem, r_quo[WIDTH-1]};
    assign w_trial    = w_remShift - {1'b0, r_magDivisor};
    assign w_fits     = ~w_trial[WIDTH];
    assign w_stepRem  = w_fits ? w_trial[WIDTH-1:0] : w_remShift[WIDTH-1:0];
    assign w_stepQuo  = {r_quo[WIDTH-2:0], w_fits};
    assign w_lastStep = (r_count == CW'(WIDTH - 1));

    always_comb begin
        w_nextState    = r_state;
        w_count        = r_count;
        w_partRem      = r_partRem;
        w_quo          = r_quo;
        w_magDivisor   = r_magDivisor;
        w_origDividend = r_origDividend;
        w_q            = r_q;
        w_r            = r_r;
        w_quoNeg       = r_quoNeg;
        w_remNeg       = r_remNeg;
        w_divZero      = r_divZero;
        w_done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (io_divBus.start) begin
                    w_nextState    = RUN;
                    w_count        = '0;
                    w_partRem      = '0;
                    w_quo          = w_magDividend;
                    w_magDivisor   = w_magDivisorIn;
                    w_origDividend = io_divBus.dividend;
                    w_quoNeg       = w_dividendNeg ^ w_divisorNeg;
                    w_remNeg       = w_dividendNeg;
                    w_divZero      = (io_divBus.divisor == '0);
                end
            end
            RUN: begin
                w_partRem = w_stepRem;
                w_quo     = w_stepQuo;
                w_count   = r_count + CW'(1);
                if (w_lastStep) begin
                    w_nextState = IDLE;
                    w_done      = 1'b1;
                    // Divide by zero bypasses sign correction and returns the raw dividend.
                    if (r_divZero) begin
                        w_q = '1;
                        w_r = r_origDividend;
                    end else begin
                        w_q = r_quoNeg ? -w_stepQuo : w_stepQuo;
                        w_r = r_remNeg ? -w_stepRem : w_stepRem;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_count        <= '0;
            r_partRem      <= '0;
            r_quo          <= '0;
            r_magDivisor   <= '0;
            r_origDividend <= '0;
            r_q            <= '0;
            r_r            <= '0;
            r_quoNeg       <= 1'b0;
            r_remNeg       <= 1'b0;
            r_divZero      <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_nextState;
            r_count        <= w_count;
            r_partRem      <= w_partRem;
            r_quo          <= w_quo;
            r_magDivisor   <= w_magDivisor;
            r_origDividend <= w_origDividend;
            r_q            <= w_q;
            r_r            <= w_r;
            r_quoNeg       <= w_quoNeg;
            r_remNeg       <= w_remNeg;
            r_divZero      <= w_divZero;
            r_done         <= w_done;
        end
    end

    assign io_divBus.busy = (r_state == RUN);
    assign io_divBus.done = r_done;
    assign io_divBus.q    = r_q;
    assign io_divBus.r    = r_r;
endmodule
